mult_share_ctrl: RTL and testbench

Controller that shares one repeated-addition multiplier datapath (XLEN x XLEN -> 2*XLEN) between NREQ requesters. It round-robin arbitrates operand requests, captures the winning operands, and sequences the datapath through load, accumulate and done phases. It returns the product, tagged with the requester index, over a valid/ready result port. The block sits between client engines and the multiplier datapath, and it alone drives every datapath control input.

---
 rtl/mult_share_if.sv | 43 ++++
 rtl/mult_share_ctrl.sv | 122 ++++++++++++
 tb/tb_mult_share_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_if.sv
// Bundle of requester, result and datapath-control signals around the
// shared multiplier controller. master = controller, slave = clients/datapath.
interface mult_share_if #(
  parameter int XLEN = 16,
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  // Requester side
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;

  // Result side
  logic                 res_valid;
  logic                 res_ready;
  logic [2*XLEN-1:0]    res_data;
  logic [IDW-1:0]       res_id;
  logic                 busy;

  // Datapath control and status
  logic                 dp_ld_input;
  logic [1:0]           dp_state;
  logic                 dp_ready;
  logic                 dp_done;
  logic [XLEN-1:0]      dp_a;
  logic [XLEN-1:0]      dp_b;
  logic                 dp_eqz;
  logic [2*XLEN-1:0]    dp_product;

  modport master (
    input  req_valid, req_a, req_b, res_ready, dp_eqz, dp_product,
    output req_ready, res_valid, res_data, res_id, busy,
           dp_ld_input, dp_state, dp_ready, dp_done, dp_a, dp_b
  );

  modport slave (
    output req_valid, req_a, req_b, res_ready, dp_eqz, dp_product,
    input  req_ready, res_valid, res_data, res_id, busy,
           dp_ld_input, dp_state, dp_ready, dp_done, dp_a, dp_b
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Shares one repeated-addition multiplier datapath between NREQ requesters:
// round-robin grant, operand capture, LOAD/OPER/DONE sequencing and a
// valid/ready result port tagged with the owning requester index.
module mult_share_ctrl #(
  parameter int XLEN = 16,
  parameter int NREQ = 4
) (
  input  logic       clk,
  input  logic       resetn,
  mult_share_if.master bus
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] DP_READY   = 2'd0;
  localparam logic [1:0] DP_OPERATE = 2'd1;
  localparam logic [1:0] DP_DONE    = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OPER, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;

  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;
  int              cand_w;

  // Round-robin pick: first valid requester after last_q, wrapping at NREQ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_w    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_w = int'(last_q) + k;
      if (cand_w >= NREQ) cand_w = cand_w - NREQ;
      if (!grant_vld && bus.req_valid[cand_w[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand_w[IDW-1:0];
      end
    end
  end

  // State, round-robin pointer and captured operands.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: operand/id registers are reset too, since dp_a, dp_b and res_id are visible with defined reset values.
      state_q <= S_IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state logic plus all handshake and datapath control outputs.
  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    id_d            = id_q;
    a_d             = a_q;
    b_d             = b_q;
    bus.req_ready   = '0;
    bus.dp_ld_input = 1'b0;
    bus.dp_state    = DP_READY;
    bus.dp_ready    = 1'b0;
    bus.dp_done     = 1'b0;
    bus.res_valid   = 1'b0;
    bus.res_data    = '0;

    unique case (state_q)
      S_IDLE: begin
        bus.dp_ready = 1'b1;
        // No grant is offered while reset is held, so nothing is accepted and lost.
        if (resetn && grant_vld) begin
          bus.req_ready[grant_idx] = 1'b1;
          a_d     = bus.req_a[grant_idx*XLEN +: XLEN];
          b_d     = bus.req_b[grant_idx*XLEN +: XLEN];
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.dp_ld_input = 1'b1;
        state_d         = S_OPER;
      end
      S_OPER: begin
        // Counter already zero: stop accumulating and move to the drive phase.
        if (bus.dp_eqz) begin
          bus.dp_state = DP_DONE;
          state_d      = S_DONE;
        end else begin
          bus.dp_state = DP_OPERATE;
        end
      end
      S_DONE: begin
        bus.dp_done   = 1'b1;
        bus.dp_state  = DP_DONE;
        bus.res_valid = 1'b1;
        bus.res_data  = bus.dp_product;
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.res_id = id_q;
  assign bus.dp_a   = a_q;
  assign bus.dp_b   = b_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: behavioural repeated-addition
// datapath, round-robin and product reference model, directed and random ops.
module tb_mult_share_ctrl;
  localparam int XLEN = 16;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_last;

  logic [XLEN-1:0] op_a [NREQ];
  logic [XLEN-1:0] op_b [NREQ];

  mult_share_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  mult_share_ctrl #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared multiplier datapath: load counter, then add a and decrement per OPERATE cycle.
  logic [XLEN-1:0]   dp_cnt = '0;
  logic [2*XLEN-1:0] dp_acc = '0;
  always @(posedge clk) begin
    if (bus.dp_ld_input) begin
      dp_cnt <= bus.dp_b;
      dp_acc <= '0;
    end else if (bus.dp_state == 2'd1) begin
      dp_acc <= dp_acc + {{XLEN{1'b0}}, bus.dp_a};
      dp_cnt <= dp_cnt - 1'b1;
    end
  end
  assign bus.dp_eqz     = (dp_cnt == '0);
  assign bus.dp_product = dp_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first valid index after last, cyclically.
  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*XLEN +: XLEN] = op_a[i];
      bus.req_b[i*XLEN +: XLEN] = op_b[i];
    end
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_res", {bus.res_valid, bus.busy, bus.res_data}, 64'(0));
    check("rst_res_id", 64'(bus.res_id), 64'(0));
    check("rst_dp_ctl", {bus.dp_ld_input, bus.dp_state, bus.dp_ready, bus.dp_done}, 64'b00010);
    check("rst_dp_ops", {bus.dp_a, bus.dp_b}, 64'(0));
  endtask

  // Wait for the grant, follow one op to its result, optionally stall, then handshake.
  task automatic serve(input int stall, input bit drop, output int gcyc);
    int n;
    int w;
    logic [63:0] pexp;
    logic [2*XLEN-1:0] sd;
    logic [1:0] sid;
    bit ok;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    w = rr_pick(bus.req_valid, model_last);
    check("grant", 64'(bus.req_ready), (w < 0) ? 64'(0) : (64'(1) << w));
    if (w < 0) w = 0;
    gcyc = cyc;
    model_last = w;
    pexp = 64'(op_a[w]) * 64'(op_b[w]);
    @(negedge clk);
    if (drop) bus.req_valid[w] = 1'b0;
    #1;
    check("load_phase", {bus.busy, bus.dp_ld_input, bus.req_ready, bus.res_data}, {2'b11, 4'b0, 32'b0});
    n = 0;
    while (!bus.res_valid && n < 70000) begin
      @(negedge clk); #1; n++;
    end
    check("latency", 64'(cyc - gcyc), 64'(op_b[w]) + 64'd3);
    check("res_data", 64'(bus.res_data), pexp);
    check("res_id", 64'(bus.res_id), 64'(w));
    if (stall > 0) begin
      bus.res_ready = 1'b0;
      sd  = bus.res_data;
      sid = bus.res_id;
      ok  = 1'b1;
      repeat (stall) begin
        @(negedge clk); #1;
        if (!(bus.res_valid && bus.res_data == sd && bus.res_id == sid && bus.req_ready == '0)) ok = 1'b0;
      end
      check("stall_stable", 64'(ok), 64'(1));
      bus.res_ready = 1'b1;
    end
    @(negedge clk); #1;
    check("post_hs", {bus.res_valid, bus.busy, bus.res_data}, 64'(0));
  endtask

  initial begin
    int g, prev;
    int n;
    bit ok;
    logic [NREQ-1:0] mask;

    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    model_last    = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals();
    resetn = 1'b1;

    // Round robin: all requesters valid with b=1, expected order 0,1,2,3,0
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = XLEN'($urandom);
      op_b[i] = 16'd1;
    end
    drive_ops();
    bus.req_valid = '1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      serve(0, 1'b0, g);
      check("rr_order", 64'(model_last), 64'(i % NREQ));
      if (i > 0) check("rr_spacing", 64'(g - prev), 64'd5);
      prev = g;
    end
    bus.req_valid = '0;

    // Single op: req0 a=7 b=5
    op_a[0] = 16'd7; op_b[0] = 16'd5;
    drive_ops();
    bus.req_valid = 4'b0001;
    serve(0, 1'b1, g);

    // Zero multiplier and zero multiplicand
    op_a[2] = 16'hFFFF; op_b[2] = 16'd0;
    drive_ops();
    bus.req_valid = 4'b0100;
    serve(0, 1'b1, g);
    op_a[3] = 16'd0; op_b[3] = 16'd9;
    drive_ops();
    bus.req_valid = 4'b1000;
    serve(0, 1'b1, g);

    // Backpressure with a waiting requester, next grant right after release
    op_a[1] = 16'd123; op_b[1] = 16'd3;
    op_a[3] = 16'd11;  op_b[3] = 16'd2;
    drive_ops();
    bus.req_valid = 4'b0010;
    #1;
    bus.req_valid = 4'b1010;
    serve(10, 1'b1, g);
    check("next_grant", 64'(bus.req_ready), 64'b1000);
    serve(0, 1'b1, g);

    // Randomised ops against the reference model
    for (int it = 0; it < 24; it++) begin
      mask = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i] && !bus.req_valid[i]) begin
          op_a[i] = XLEN'($urandom);
          op_b[i] = XLEN'($urandom_range(0, 12));
        end
      end
      drive_ops();
      bus.req_valid = mask;
      serve(int'($urandom_range(0, 3)), 1'b1, g);
    end
    bus.req_valid = '0;

    // Maximum operands
    op_a[1] = 16'hFFFF; op_b[1] = 16'hFFFF;
    drive_ops();
    bus.req_valid = 4'b0010;
    serve(0, 1'b1, g);

    // Reset in the middle of OPER aborts the op
    op_a[0] = 16'd3; op_b[0] = 16'd100;
    drive_ops();
    bus.req_valid = 4'b0001;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("abort_grant", 64'(bus.req_ready), 64'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk); #1;
    check_reset_vals();
    resetn = 1'b1;
    model_last = NREQ - 1;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      if (bus.res_valid || bus.busy) ok = 1'b0;
    end
    check("abort_quiet", 64'(ok), 64'(1));
    op_a[1] = 16'd4; op_b[1] = 16'd4;
    drive_ops();
    bus.req_valid = 4'b0010;
    serve(0, 1'b1, g);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
